// File: rtl/modexp_seq_ctrl_if.sv
// rtl/modexp_seq_ctrl_if.sv - operand stream, core and result bus of the modexp sequencer
interface modexp_seq_ctrl_if #(
  parameter int N = 8,
  parameter int W = 4
);
  logic [W-1:0]   in_data;
  logic           in_valid;
  logic           in_ready;
  logic           core_rst;
  logic [N-1:0]   core_g;
  logic [2*N-1:0] core_e;
  logic [N-1:0]   core_o;
  logic [N-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic           busy;

  // slave: the sequencer itself; master: the surrounding environment
  modport slave (
    input  in_data, in_valid, core_o, out_ready,
    output in_ready, core_rst, core_g, core_e, out_data, out_valid, busy
  );

  modport master (
    output in_data, in_valid, core_o, out_ready,
    input  in_ready, core_rst, core_g, core_e, out_data, out_valid, busy
  );
endinterface

// File: rtl/modexp_seq_ctrl.sv
// rtl/modexp_seq_ctrl.sv - loads m/e/n word streams, kicks the modexp core, captures its result
module modexp_seq_ctrl #(
  parameter int N   = 8,
  parameter int W   = 4,
  parameter int CC  = N,
  parameter int LAT = CC
) (
  input  logic            clk,
  input  logic            rst,
  modexp_seq_ctrl_if.slave bus
);

  localparam int WPO = N / W;
  localparam int WCW = (WPO > 1) ? $clog2(WPO) : 1;
  localparam int RCW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [WCW-1:0] WC_LAST = WCW'(WPO - 1);
  localparam logic [RCW-1:0] RC_LAST = RCW'(LAT - 1);

  typedef enum logic [2:0] {
    LOAD_M = 3'd0,
    LOAD_E = 3'd1,
    LOAD_N = 3'd2,
    KICK   = 3'd3,
    RUN    = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [WCW-1:0] word_cnt;
  logic [RCW-1:0] run_cnt;
  logic [N-1:0]   m_reg;
  logic [N-1:0]   e_reg;
  logic [N-1:0]   n_reg;
  logic [N-1:0]   out_q;
  logic           out_v;

  logic           rdy;
  logic           crst;
  logic           bsy;
  logic           ld_m;
  logic           ld_e;
  logic           ld_n;
  logic           capture;
  logic           ack;
  logic           last_word;

  assign last_word = (word_cnt == WC_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD_M;
    end else begin
      state <= state_nx;
    end
  end

  // in_ready is high only in the LOAD states, so a valid word there is a transfer
  always_comb begin
    state_nx = state;
    rdy      = 1'b0;
    crst     = 1'b1;
    bsy      = 1'b0;
    ld_m     = 1'b0;
    ld_e     = 1'b0;
    ld_n     = 1'b0;
    capture  = 1'b0;
    ack      = 1'b0;
    case (state)
      LOAD_M: begin
        rdy  = 1'b1;
        ld_m = bus.in_valid;
        if (bus.in_valid && last_word) begin
          state_nx = LOAD_E;
        end
      end
      LOAD_E: begin
        rdy  = 1'b1;
        ld_e = bus.in_valid;
        if (bus.in_valid && last_word) begin
          state_nx = LOAD_N;
        end
      end
      LOAD_N: begin
        rdy  = 1'b1;
        ld_n = bus.in_valid;
        if (bus.in_valid && last_word) begin
          state_nx = KICK;
        end
      end
      KICK: begin
        bsy      = 1'b1;
        state_nx = RUN;
      end
      RUN: begin
        bsy  = 1'b1;
        crst = 1'b0;
        if (run_cnt == RC_LAST) begin
          capture  = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          ack      = 1'b1;
          state_nx = LOAD_M;
        end
      end
      default: begin
        state_nx = LOAD_M;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt <= '0;
      run_cnt  <= '0;
      m_reg    <= '0;
      e_reg    <= '0;
      n_reg    <= '0;
      out_q    <= '0;
      out_v    <= 1'b0;
    end else begin
      if (ld_m || ld_e || ld_n) begin
        word_cnt <= last_word ? '0 : word_cnt + 1'b1;
      end

      for (int k = 0; k < WPO; k++) begin
        if (word_cnt == WCW'(k)) begin
          if (ld_m) m_reg[k*W +: W] <= bus.in_data;
          if (ld_e) e_reg[k*W +: W] <= bus.in_data;
          if (ld_n) n_reg[k*W +: W] <= bus.in_data;
        end
      end

      if (state == RUN) begin
        run_cnt <= capture ? '0 : run_cnt + 1'b1;
      end

      // out_q deliberately keeps its value across the handshake
      if (capture) begin
        out_q <= bus.core_o;
        out_v <= 1'b1;
      end else if (ack) begin
        out_v <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.core_rst  = crst;
  assign bus.busy      = bsy;
  assign bus.core_g    = m_reg;
  assign bus.core_e    = {n_reg, e_reg};
  assign bus.out_data  = out_q;
  assign bus.out_valid = out_v;

endmodule

// File: tb/tb_modexp_seq_ctrl.sv
// tb/tb_modexp_seq_ctrl.sv - bench for modexp_seq_ctrl with W=4 and W=8 instances and a core model
module tb_modexp_seq_ctrl;
  localparam int N   = 8;
  localparam int LAT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  modexp_seq_ctrl_if #(.N(N), .W(4)) if0 ();
  modexp_seq_ctrl_if #(.N(N), .W(8)) if1 ();

  modexp_seq_ctrl #(.N(N), .W(4), .CC(N), .LAT(LAT)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  modexp_seq_ctrl #(.N(N), .W(8), .CC(N), .LAT(LAT)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int xf0 = 0;
  int xf1 = 0;
  int last_edge = 0;
  logic [3:0] cc0 = '0;
  logic [3:0] cc1 = '0;

  function automatic logic [7:0] ref_pow(int m, int e, int n);
    longint r = 1;
    longint b = m % n;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = (r * b) % n;
      b = (b * b) % n;
    end
    return 8'(r % n);
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (if0.in_valid && if0.in_ready) xf0 <= xf0 + 1;
    if (if1.in_valid && if1.in_ready) xf1 <= xf1 + 1;
    cc0 <= if0.core_rst ? 4'd0 : ((cc0 == 4'd15) ? cc0 : cc0 + 4'd1);
    cc1 <= if1.core_rst ? 4'd0 : ((cc1 == 4'd15) ? cc1 : cc1 + 4'd1);
  end

  // core model: garbage (complement of the answer) until LAT cycles after core_rst drops
  assign if0.core_o = (cc0 >= 4'(LAT - 1)) ?
    ref_pow(int'(if0.core_g), int'(if0.core_e[7:0]), int'(if0.core_e[15:8])) :
    ~ref_pow(int'(if0.core_g), int'(if0.core_e[7:0]), int'(if0.core_e[15:8]));
  assign if1.core_o = (cc1 >= 4'(LAT - 1)) ?
    ref_pow(int'(if1.core_g), int'(if1.core_e[7:0]), int'(if1.core_e[15:8])) :
    ~ref_pow(int'(if1.core_g), int'(if1.core_e[7:0]), int'(if1.core_e[15:8]));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input int data, input logic v);
    if (sel == 0) begin
      if0.in_data  = 4'(data);
      if0.in_valid = v;
    end else begin
      if1.in_data  = 8'(data);
      if1.in_valid = v;
    end
  endtask

  task automatic set_oready(input int sel, input logic v);
    if (sel == 0) if0.out_ready = v;
    else          if1.out_ready = v;
  endtask

  function automatic logic rdy(int sel);  return sel ? if1.in_ready  : if0.in_ready;  endfunction
  function automatic logic ov(int sel);   return sel ? if1.out_valid : if0.out_valid; endfunction
  function automatic logic crst(int sel); return sel ? if1.core_rst  : if0.core_rst;  endfunction
  function automatic logic bsy(int sel);  return sel ? if1.busy      : if0.busy;      endfunction
  function automatic logic [7:0] od(int sel);  return sel ? if1.out_data : if0.out_data; endfunction
  function automatic logic [7:0] cg(int sel);  return sel ? if1.core_g   : if0.core_g;   endfunction
  function automatic logic [15:0] ce(int sel); return sel ? if1.core_e   : if0.core_e;   endfunction
  function automatic int xf(int sel);          return sel ? xf1 : xf0;                     endfunction

  // mode 0: in_valid held high, 1: valid pattern 1,0,0 repeating, 2: random bubbles
  task automatic send_vec(input int sel, input int m, input int e, input int n, input int mode);
    int w = sel ? 8 : 4;
    int wpo = 8 / w;
    int ops[3];
    int pat = 0;
    int guard = 0;
    ops[0] = m; ops[1] = e; ops[2] = n;
    for (int op = 0; op < 3; op++) begin
      for (int k = 0; k < wpo; k++) begin
        int word = (ops[op] >> (k * w)) & ((1 << w) - 1);
        logic accepted = 1'b0;
        while (!accepted && guard < 500) begin
          logic v;
          logic r;
          v = (mode == 0) ? 1'b1 : (mode == 1) ? (pat % 3 == 0) : 1'($urandom % 2);
          pat++;
          drive(sel, v ? word : int'($urandom), v);
          r = rdy(sel);
          tick;
          guard++;
          if (v && r) accepted = 1'b1;
        end
      end
    end
    drive(sel, 0, 1'b0);
    last_edge = cyc;
    check("send_timeout", guard < 500, 1);
  endtask

  task automatic do_vec(input int sel, input int m, input int e, input int n, input int mode,
                        input int bp, input logic tied, input logic [7:0] exp, input string tag);
    int x0 = xf(sel);
    int low = 0;
    int bz = 0;
    int guard = 0;
    int xb;
    logic stable = 1'b1;
    logic rdy_bad = 1'b0;
    logic bp_ok = 1'b1;
    logic quiet = 1'b1;
    set_oready(sel, tied);
    send_vec(sel, m, e, n, mode);
    check({tag, "_core_g"}, cg(sel), 64'(m));
    check({tag, "_core_e"}, ce(sel), 64'((n << 8) | e));
    while (!ov(sel) && guard < 100) begin
      if (!crst(sel)) low++;
      if (bsy(sel)) bz++;
      if (bsy(sel) && rdy(sel)) rdy_bad = 1'b1;
      if (cg(sel) != 8'(m) || ce(sel) != 16'((n << 8) | e)) stable = 1'b0;
      tick;
      guard++;
    end
    check({tag, "_timeout"}, guard < 100, 1);
    check({tag, "_latency"}, cyc - last_edge + 1, LAT + 2);
    check({tag, "_core_rst_low"}, low, LAT);
    check({tag, "_busy_cycles"}, bz, LAT + 1);
    check({tag, "_operands_stable"}, stable, 1);
    check({tag, "_no_ready_busy"}, rdy_bad, 0);
    check({tag, "_out_data"}, od(sel), exp);
    if (bp > 0) begin
      xb = xf(sel);
      for (int i = 0; i < bp; i++) begin
        drive(sel, int'($urandom), 1'b1);
        if (!ov(sel) || od(sel) != exp || rdy(sel) || !crst(sel)) bp_ok = 1'b0;
        tick;
      end
      drive(sel, 0, 1'b0);
      check({tag, "_bp_hold"}, bp_ok, 1);
      check({tag, "_bp_no_xfer"}, xf(sel) - xb, 0);
    end
    set_oready(sel, 1'b1);
    tick;
    check({tag, "_ack_valid"}, ov(sel), 0);
    check({tag, "_ack_ready"}, rdy(sel), 1);
    check({tag, "_ack_hold"}, od(sel), exp);
    set_oready(sel, tied);
    for (int i = 0; i < 3; i++) begin
      if (ov(sel)) quiet = 1'b0;
      tick;
    end
    set_oready(sel, 1'b0);
    check({tag, "_no_reemit"}, quiet, 1);
    check({tag, "_xfers"}, xf(sel) - x0, (sel ? 3 : 6));
  endtask

  initial begin
    int low;
    int guard;
    if0.in_data = '0; if0.in_valid = 1'b0; if0.out_ready = 1'b0;
    if1.in_data = '0; if1.in_valid = 1'b0; if1.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) tick;
    check("rst_out_valid", if0.out_valid, 0);
    check("rst_core_rst", if0.core_rst, 1);
    check("rst_busy", if0.busy, 0);
    check("rst_out_data", if0.out_data, 0);
    check("rst_core_g", if0.core_g, 0);
    check("rst_core_e", if0.core_e, 0);
    check("rst_out_valid_w8", if1.out_valid, 0);
    rst = 1'b0;
    tick;
    check("rst_in_ready", if0.in_ready, 1);
    check("rst_in_ready_w8", if1.in_ready, 1);

    do_vec(0, 5, 3, 13, 0, 10, 1'b0, 8'h08, "basic_bp");
    do_vec(0, 2, 5, 11, 0, 0, 1'b1, 8'h0A, "b2b");
    do_vec(0, 5, 3, 13, 1, 0, 1'b0, 8'h08, "bubbles");

    send_vec(0, 5, 3, 13, 0);
    low = 0;
    guard = 0;
    while (low < 3 && guard < 50) begin
      if (!if0.core_rst) low++;
      if (low < 3) tick;
      guard++;
    end
    check("midrun_reached", low, 3);
    rst = 1'b1;
    #1;
    check("midrun_out_valid", if0.out_valid, 0);
    check("midrun_core_rst", if0.core_rst, 1);
    check("midrun_busy", if0.busy, 0);
    tick;
    rst = 1'b0;
    tick;
    check("midrun_in_ready", if0.in_ready, 1);
    check("midrun_out_data", if0.out_data, 0);
    do_vec(0, 5, 3, 13, 0, 0, 1'b0, 8'h08, "after_midrun");

    drive(0, 7, 1'b1); tick;
    drive(0, 0, 1'b1); tick;
    drive(0, 9, 1'b1); tick;
    drive(0, 0, 1'b0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
    do_vec(0, 5, 3, 13, 2, 0, 1'b0, 8'h08, "after_midload");

    do_vec(1, 5, 3, 13, 0, 0, 1'b0, 8'h08, "w8_basic");

    for (int i = 0; i < 16; i++) begin
      int n = int'($urandom_range(3, 255)) | 1;
      int m = int'($urandom_range(0, n - 1));
      int e = int'($urandom_range(1, 255));
      int sel = (i % 4 == 3) ? 1 : 0;
      logic tied = 1'($urandom % 2);
      int bp = tied ? 0 : int'($urandom_range(0, 3));
      do_vec(sel, m, e, n, 2, bp, tied, ref_pow(m, e, n), $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
